// File: rtl/key_debounce_if.sv
// Key debouncer bus: raw key pins in, debounced level, strobes and busy flags out.
// The board/bench side uses the master modport and the debouncer uses the slave modport.
interface key_debounce_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] key_raw;
  logic [WIDTH-1:0] key_out;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;
  logic [WIDTH-1:0] busy;

  modport master (
    output key_raw,
    input  key_out,
    input  press_pulse,
    input  release_pulse,
    input  busy
  );

  modport slave (
    input  key_raw,
    output key_out,
    output press_pulse,
    output release_pulse,
    output busy
  );
endinterface

// File: rtl/key_debounce.sv
// Per-channel push-button synchronizer and debouncer.
// Each channel has a two-flop synchronizer and a two-state qualifier FSM.
// The FSM moves the debounced level only after the synchronized input has
// disagreed with it on DEBOUNCE_CYCLES+1 consecutive edges. Every output is
// a flop, so there is no combinational path from the raw pins.
module key_debounce #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic           clk,
  input  logic           reset,
  key_debounce_if.slave  bus
);

  // The width floor only keeps declarations legal while the range error below fires.
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic REL     = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic PRESSED = ~REL;

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
      $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic             r_s1;
      logic             r_s2;
      logic             r_stable;
      logic             r_press;
      logic             r_release;
      logic             r_busy;
      logic [CNT_W-1:0] r_cnt;
      state_t           r_state;
      logic             w_diff;
      logic             w_cnt_done;

      assign w_diff     = (r_s2 != r_stable);
      assign w_cnt_done = (r_cnt == CNT_MAX);

      // Two-flop synchronizer for the asynchronous key pin.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_s1 <= REL;
          r_s2 <= REL;
        end else begin
          r_s1 <= bus.key_raw[gi];
          r_s2 <= r_s1;
        end
      end

      // Qualifier FSM: any return to the stable level restarts from zero.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_stable  <= REL;
          r_busy    <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_press   <= 1'b0;
          r_release <= 1'b0;
          case (r_state)
            ST_IDLE: begin
              r_cnt <= '0;
              if (w_diff) begin
                r_state <= ST_WAIT;
                r_busy  <= 1'b1;
              end
            end
            ST_WAIT: begin
              if (!w_diff) begin
                // Bounce came back before qualification finished.
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
              end else if (w_cnt_done) begin
                // New level held long enough; commit it and strobe once.
                r_stable <= r_s2;
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_busy   <= 1'b0;
                if (r_s2 == PRESSED) begin
                  r_press <= 1'b1;
                end else begin
                  r_release <= 1'b1;
                end
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end

      assign bus.key_out[gi]       = r_stable;
      assign bus.press_pulse[gi]   = r_press;
      assign bus.release_pulse[gi] = r_release;
      assign bus.busy[gi]          = r_busy;
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce (WIDTH=2, DEBOUNCE_CYCLES=4, active-low keys).
// A reference model built on "consecutive disagreeing edges" runs on every
// clock edge. A hand-computed vector table, corner-case sequences and
// random stimulus are all checked against it.
module tb_key_debounce;
  localparam int W   = 2;
  localparam int D   = 4;
  localparam logic REL     = 1'b1;
  localparam logic PRESSED = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  key_debounce_if #(.WIDTH(W)) bus ();

  key_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a delayed copy of the raw pins plus a run length of
  // consecutive edges on which the delayed input disagreed with the stable level.
  logic [W-1:0] m_s1 = '1, m_s2 = '1, m_stable = '1, m_press = '0, m_rel = '0;
  int m_run [W];

  task automatic model_edge(input logic rst, input logic [W-1:0] raw);
    m_press = '0;
    m_rel   = '0;
    if (rst) begin
      m_s1 = {W{REL}};
      m_s2 = {W{REL}};
      m_stable = {W{REL}};
      for (int c = 0; c < W; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < W; c++) begin
        if (m_s2[c] != m_stable[c]) m_run[c] = m_run[c] + 1;
        else m_run[c] = 0;
        if (m_run[c] == D + 1) begin
          m_stable[c] = m_s2[c];
          m_run[c] = 0;
          if (m_s2[c] == PRESSED) m_press[c] = 1'b1;
          else m_rel[c] = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  function automatic logic [W-1:0] model_busy();
    logic [W-1:0] b;
    for (int c = 0; c < W; c++) b[c] = (m_run[c] != 0);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, update the model, compare #1 later.
  task automatic step(input logic rst, input logic [W-1:0] raw);
    reset = rst;
    bus.key_raw = raw;
    @(posedge clk);
    model_edge(rst, raw);
    #1;
    chk("model", {bus.key_out, bus.press_pulse, bus.release_pulse, bus.busy},
        {m_stable, m_press, m_rel, model_busy()});
    chk("excl", bus.press_pulse & bus.release_pulse, 0);
  endtask

  task automatic settle();
    repeat (12) step(1'b0, 2'b11);
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] k, p, r, b;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(input logic rst, input logic [1:0] raw, input logic [1:0] k,
                              input logic [1:0] p, input logic [1:0] r, input logic [1:0] b);
    vec_t v;
    v.rst = rst; v.raw = raw; v.k = k; v.p = p; v.r = r; v.b = b;
    return v;
  endfunction

  // Tracks how long each raw channel keeps its level in the random phase.
  logic [W-1:0] rnd_raw;
  int rnd_rem [W];

  initial begin
    int f0, f1, pc0, pc1, rel11, pcnt, rcnt, rel_at, fall_at;
    logic fell;
    bus.key_raw = 2'b00;

    // Inputs for edge i, expected outputs right after edge i.
    tbl[0]  = mk(1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[1]  = mk(1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[2]  = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[3]  = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[4]  = mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00);  // E0
    tbl[5]  = mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[6]  = mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01);  // E0+2
    tbl[7]  = mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01);
    tbl[8]  = mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01);
    tbl[9]  = mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01);
    tbl[10] = mk(0, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00);  // E0+6
    tbl[11] = mk(0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    tbl[12] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);  // release capture
    tbl[13] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00);
    tbl[14] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01);
    tbl[15] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01);
    tbl[16] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01);
    tbl[17] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01);
    tbl[18] = mk(0, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00);
    tbl[19] = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[20] = mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00);  // 3-cycle bounce
    tbl[21] = mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[22] = mk(0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01);
    tbl[23] = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01);
    tbl[24] = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01);
    tbl[25] = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    tbl[26] = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].rst, tbl[i].raw);
      chk($sformatf("vec%0d", i), {bus.key_out, bus.press_pulse, bus.release_pulse, bus.busy},
          {tbl[i].k, tbl[i].p, tbl[i].r, tbl[i].b});
      $display("vec %0d rst=%b raw=%b key_out=%b press=%b release=%b busy=%b", i, tbl[i].rst,
               tbl[i].raw, bus.key_out, bus.press_pulse, bus.release_pulse, bus.busy);
    end

    // Bounce of 4 and 5 low cycles on channel 0.
    for (int n = 4; n <= 5; n++) begin
      settle();
      fell = 1'b0;
      pcnt = 0;
      for (int i = 0; i < n + 12; i++) begin
        step(1'b0, (i < n) ? 2'b10 : 2'b11);
        if (bus.key_out[0] == 1'b0) fell = 1'b1;
        if (bus.press_pulse[0]) pcnt++;
      end
      chk($sformatf("bounce%0d_fell", n), fell, (n == 5) ? 1 : 0);
      chk($sformatf("bounce%0d_press", n), pcnt, (n == 5) ? 1 : 0);
      $display("bounce low=%0d fell=%b presses=%0d", n, fell, pcnt);
    end

    // Independence: channel 1 pressed two cycles after channel 0.
    settle();
    f0 = -1; f1 = -1; pc0 = 0; pc1 = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, {(i >= 2) ? 1'b0 : 1'b1, 1'b0});
      if (bus.key_out[0] == 1'b0 && f0 < 0) f0 = i;
      if (bus.key_out[1] == 1'b0 && f1 < 0) f1 = i;
      if (bus.press_pulse[0]) pc0++;
      if (bus.press_pulse[1]) pc1++;
    end
    chk("indep_fall0", f0, 6);
    chk("indep_gap", f1 - f0, 2);
    chk("indep_press0", pc0, 1);
    chk("indep_press1", pc1, 1);
    rel11 = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 2'b11);
      if (bus.release_pulse == 2'b11) rel11++;
    end
    chk("indep_rel11", rel11, 1);
    chk("indep_keyout", bus.key_out, 2'b11);
    $display("independence fall0=%0d fall1=%0d presses=%0d/%0d rel11=%0d", f0, f1, pc0, pc1, rel11);

    // Reset in the middle of a qualification, key held pressed throughout.
    settle();
    repeat (3) step(1'b0, 2'b10);
    chk("midwait_busy", bus.busy[0], 1);
    repeat (2) step(1'b1, 2'b10);
    chk("midwait_rst_out", bus.key_out, 2'b11);
    chk("midwait_rst_busy", bus.busy, 2'b00);
    fall_at = -1;
    pcnt = 0;
    for (int e = 0; e < 16; e++) begin
      step(1'b0, 2'b10);
      if (bus.key_out[0] == 1'b0 && fall_at < 0) fall_at = e;
      if (bus.press_pulse[0]) pcnt++;
    end
    chk("midwait_fall", fall_at, 6);
    chk("midwait_press", pcnt, 1);
    $display("reset mid-wait fall at edge %0d presses=%0d", fall_at, pcnt);

    // Long hold followed by release.
    settle();
    pcnt = 0; rcnt = 0; rel_at = -1;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 2'b10);
      if (bus.press_pulse[0]) pcnt++;
      if (bus.release_pulse[0]) rcnt++;
    end
    for (int e = 0; e < 15; e++) begin
      step(1'b0, 2'b11);
      if (bus.press_pulse[0]) pcnt++;
      if (bus.release_pulse[0]) begin
        rcnt++;
        if (rel_at < 0) rel_at = e;
      end
    end
    chk("long_press", pcnt, 1);
    chk("long_release", rcnt, 1);
    chk("long_rel_at", rel_at, 6);
    $display("long hold presses=%0d releases=%0d release at edge %0d", pcnt, rcnt, rel_at);

    // Random glitch trains with occasional resets, checked against the model.
    rnd_raw = 2'b11;
    for (int c = 0; c < W; c++) rnd_rem[c] = 1;
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 500; i++) begin
        for (int c = 0; c < W; c++) begin
          rnd_rem[c]--;
          if (rnd_rem[c] <= 0) begin
            rnd_raw[c] = ~rnd_raw[c];
            rnd_rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20)
                                                     : $urandom_range(1, 8);
          end
        end
        step(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, rnd_raw);
      end
      $display("random block %0d done, checks=%0d errors=%0d", blk, checks, errors);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
